mem_arbiter: RTL and testbench

- Sits directly downstream of the I-cache/D-cache control block and owns the single shared multi-cycle main memory.
- Accepts three request sources:
  - I-cache block fill
  - D-cache block fill
  - D-cache write-through store
- Arbitrates between them and sequences the 8-word pipelined block fill.
- Returns word-by-word fill data with a one-hot word select and a tag-write strobe, so the cache arrays are written directly.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter_fill_sequencer.sv | 48 ++++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants, field positions and state encoding for the main-memory arbiter.
package mem_arb_pkg;

    localparam int MEM_LATENCY = 4;
    localparam int WORDS       = 8;
    localparam int AW          = 16;
    localparam int DW          = 16;

    // Byte address = {block base, word offset, byte-in-word}
    localparam int OFF_LSB  = 1;
    localparam int OFF_MSB  = 3;
    localparam int BASE_LSB = 4;
    localparam int BASE_MSB = AW - 1;
    localparam int CNT_W    = OFF_MSB - OFF_LSB + 1;
    localparam int BASE_W   = BASE_MSB - BASE_LSB + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        FILL_DC = 2'd2,
        FILL_IC = 2'd3
    } arb_state_t;

    function automatic logic [AW-1:0] word_addr(input logic [BASE_W-1:0] base,
                                                input logic [CNT_W-1:0]  idx);
        return {base, idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/fill signals and the main-memory port of the arbiter.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              ic_req;
    logic [AW-1:0]     ic_addr;
    logic              ic_grant;
    logic              ic_wvalid;
    logic [WORDS-1:0]  ic_word_sel;
    logic              ic_done;

    logic              dc_req;
    logic [AW-1:0]     dc_addr;
    logic              dc_grant;
    logic              dc_wvalid;
    logic [WORDS-1:0]  dc_word_sel;
    logic              dc_done;

    logic              wt_req;
    logic [AW-1:0]     wt_addr;
    logic [DW-1:0]     wt_data;
    logic              wt_ack;

    logic [DW-1:0]     fill_data;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wr;
    logic              mem_en;
    logic [DW-1:0]     mem_rdata;
    logic              mem_data_valid;

    // Arbiter view
    modport master (
        input  ic_req, ic_addr, dc_req, dc_addr, wt_req, wt_addr, wt_data,
               mem_rdata, mem_data_valid,
        output ic_grant, ic_wvalid, ic_word_sel, ic_done,
               dc_grant, dc_wvalid, dc_word_sel, dc_done,
               wt_ack, fill_data, mem_addr, mem_wdata, mem_wr, mem_en
    );

    // Caches + memory view
    modport slave (
        output ic_req, ic_addr, dc_req, dc_addr, wt_req, wt_addr, wt_data,
               mem_rdata, mem_data_valid,
        input  ic_grant, ic_wvalid, ic_word_sel, ic_done,
               dc_grant, dc_wvalid, dc_word_sel, dc_done,
               wt_ack, fill_data, mem_addr, mem_wdata, mem_wr, mem_en
    );

endinterface

// File: rtl/mem_arbiter_fill_sequencer.sv
// Pipelined block-fill engine: issues WORDS read addresses back to back and
// tags each returning beat with a one-hot word select; last beat strobes done.
module fill_sequencer
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic [BASE_W-1:0] base,
    input  logic              mem_data_valid,
    input  logic [DW-1:0]     mem_rdata,
    output logic              issue,
    output logic [AW-1:0]     issue_addr,
    output logic              beat,
    output logic [WORDS-1:0]  word_sel,
    output logic [DW-1:0]     beat_data,
    output logic              done
);

    // MSB of icnt_reg set means all WORDS addresses have been issued
    logic [CNT_W:0]   icnt_reg;
    logic [CNT_W-1:0] rcnt_reg;

    always_ff @(posedge clk) begin
        if (rst || !active || done) begin
            icnt_reg <= '0;
            rcnt_reg <= '0;
        end else begin
            if (!icnt_reg[CNT_W]) begin
                icnt_reg <= icnt_reg + 1'b1;
            end
            if (mem_data_valid) begin
                rcnt_reg <= rcnt_reg + 1'b1;
            end
        end
    end

    assign issue      = active && !icnt_reg[CNT_W];
    assign issue_addr = issue ? word_addr(base, icnt_reg[CNT_W-1:0]) : '0;
    assign beat       = active && mem_data_valid;
    assign beat_data  = beat ? mem_rdata : '0;
    assign done       = beat && (rcnt_reg == CNT_W'(WORDS - 1));

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_sel
        assign word_sel[gi] = beat && (rcnt_reg == CNT_W'(gi));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: write-through stores beat D fills beat I fills;
// one fill sequencer is shared and its outputs steered to the granted cache.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    arb_state_t        state_reg, state_next;
    logic [BASE_W-1:0] base_reg;
    logic [AW-1:0]     wt_addr_reg;
    logic [DW-1:0]     wt_data_reg;

    logic              seq_active;
    logic              seq_issue;
    logic [AW-1:0]     seq_issue_addr;
    logic              seq_beat;
    logic [WORDS-1:0]  seq_word_sel;
    logic [DW-1:0]     seq_data;
    logic              seq_done;

    // Fills always start at word 0, so the in-block offset is never used
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ic_addr[OFF_MSB:0], bus.dc_addr[OFF_MSB:0]};

    assign seq_active = (state_reg == FILL_DC) || (state_reg == FILL_IC);

    fill_sequencer u_seq (
        .clk            (clk),
        .rst            (rst),
        .active         (seq_active),
        .base           (base_reg),
        .mem_data_valid (bus.mem_data_valid),
        .mem_rdata      (bus.mem_rdata),
        .issue          (seq_issue),
        .issue_addr     (seq_issue_addr),
        .beat           (seq_beat),
        .word_sel       (seq_word_sel),
        .beat_data      (seq_data),
        .done           (seq_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            base_reg    <= '0;
            wt_addr_reg <= '0;
            wt_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                base_reg    <= bus.dc_req ? bus.dc_addr[BASE_MSB:BASE_LSB]
                                          : bus.ic_addr[BASE_MSB:BASE_LSB];
                wt_addr_reg <= bus.wt_addr;
                wt_data_reg <= bus.wt_data;
            end
        end
    end

    // D side first: its miss belongs to the older instruction
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.wt_req)      state_next = WRITE;
                else if (bus.dc_req) state_next = FILL_DC;
                else if (bus.ic_req) state_next = FILL_IC;
            end
            WRITE:   state_next = IDLE;
            FILL_DC: if (seq_done) state_next = IDLE;
            FILL_IC: if (seq_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ic_grant    = 1'b0;
        bus.ic_wvalid   = 1'b0;
        bus.ic_word_sel = '0;
        bus.ic_done     = 1'b0;
        bus.dc_grant    = 1'b0;
        bus.dc_wvalid   = 1'b0;
        bus.dc_word_sel = '0;
        bus.dc_done     = 1'b0;
        bus.wt_ack      = 1'b0;
        bus.fill_data   = seq_data;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.mem_wr      = 1'b0;
        bus.mem_en      = 1'b0;
        case (state_reg)
            WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = wt_addr_reg;
                bus.mem_wdata = wt_data_reg;
                bus.wt_ack    = 1'b1;
            end
            FILL_DC: begin
                bus.dc_grant    = 1'b1;
                bus.dc_wvalid   = seq_beat;
                bus.dc_word_sel = seq_word_sel;
                bus.dc_done     = seq_done;
                bus.mem_en      = seq_issue;
                bus.mem_addr    = seq_issue_addr;
            end
            FILL_IC: begin
                bus.ic_grant    = 1'b1;
                bus.ic_wvalid   = seq_beat;
                bus.ic_word_sel = seq_word_sel;
                bus.ic_done     = seq_done;
                bus.mem_en      = seq_issue;
                bus.mem_addr    = seq_issue_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a pipelined memory model and
// cycle-stamped scoreboards for issues, fill beats, done strobes and stores.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears MEM_LATENCY cycles after the address
    logic [MEM_LATENCY-1:0] pv = '0;
    logic [15:0]            pa [MEM_LATENCY];
    logic                   stray_v = 1'b0;

    always @(posedge clk) begin
        pv    <= {pv[MEM_LATENCY-2:0], bus.mem_en & ~bus.mem_wr};
        pa[0] <= bus.mem_addr;
        for (int i = 1; i < MEM_LATENCY; i++) pa[i] <= pa[i-1];
    end

    assign bus.mem_data_valid = pv[MEM_LATENCY-1] | stray_v;
    assign bus.mem_rdata      = stray_v ? 16'hDEAD : (pa[MEM_LATENCY-1] ^ 16'hA5A5);

    logic [72:0] all_outs;
    assign all_outs = {bus.ic_grant, bus.ic_wvalid, bus.ic_word_sel, bus.ic_done,
                       bus.dc_grant, bus.dc_wvalid, bus.dc_word_sel, bus.dc_done,
                       bus.wt_ack, bus.fill_data, bus.mem_addr, bus.mem_wdata,
                       bus.mem_wr, bus.mem_en};

    // Scoreboards, each entry stamped with the cycle it must appear in
    logic [47:0] exp_issue [$];   // {cyc, addr}
    logic [65:0] exp_beat  [$];   // {cyc, icv, dcv, ic_sel, dc_sel, data}
    logic [33:0] exp_done  [$];   // {cyc, ic_done, dc_done}
    logic [65:0] exp_write [$];   // {cyc, mem_en, wt_ack, addr, data}

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_fill(input logic side_ic, input int n0, input logic [15:0] addr,
                             input int n_issue, input int n_beat, input bit with_done);
        logic [15:0] base;
        logic [15:0] a;
        logic [7:0]  sel;
        base = addr & 16'hFFF0;
        for (int i = 0; i < n_issue; i++) begin
            a = base + 16'(2 * i);
            exp_issue.push_back({32'(n0 + 1 + i), a});
        end
        for (int i = 0; i < n_beat; i++) begin
            a   = base + 16'(2 * i);
            sel = 8'h01 << i;
            exp_beat.push_back({32'(n0 + 1 + MEM_LATENCY + i), side_ic, ~side_ic,
                                side_ic ? sel : 8'h00, side_ic ? 8'h00 : sel,
                                a ^ 16'hA5A5});
        end
        if (with_done)
            exp_done.push_back({32'(n0 + WORDS + MEM_LATENCY), side_ic, ~side_ic});
    endtask

    task automatic wait_for(input int which, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            case (which)
                0:       seen = bus.ic_done;
                1:       seen = bus.dc_done;
                default: seen = bus.wt_ack;
            endcase
        end
        check({tag, "_seen"}, 128'(seen), 128'(1));
    endtask

    // Monitor: every observed event must match the head of its scoreboard
    always @(negedge clk) begin
        logic [47:0] ei;
        logic [65:0] eb;
        logic [33:0] ed;
        logic [65:0] ew;
        if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b0) begin
            ei = (exp_issue.size() != 0) ? exp_issue.pop_front() : '1;
            check("issue", {cyc, bus.mem_addr}, ei);
        end
        if (bus.mem_wr === 1'b1 || bus.wt_ack === 1'b1) begin
            ew = (exp_write.size() != 0) ? exp_write.pop_front() : '1;
            check("write", {cyc, bus.mem_en, bus.wt_ack, bus.mem_addr, bus.mem_wdata}, ew);
        end
        if (bus.ic_wvalid === 1'b1 || bus.dc_wvalid === 1'b1) begin
            eb = (exp_beat.size() != 0) ? exp_beat.pop_front() : '1;
            check("beat", {cyc, bus.ic_wvalid, bus.dc_wvalid, bus.ic_word_sel,
                           bus.dc_word_sel, bus.fill_data}, eb);
        end
        if (bus.ic_done === 1'b1 || bus.dc_done === 1'b1) begin
            ed = (exp_done.size() != 0) ? exp_done.pop_front() : '1;
            check("done", {cyc, bus.ic_done, bus.dc_done}, ed);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.ic_req = 1'b0; bus.ic_addr = '0;
        bus.dc_req = 1'b0; bus.dc_addr = '0;
        bus.wt_req = 1'b0; bus.wt_addr = '0; bus.wt_data = '0;

        repeat (3) step();
        check("reset_outs", 128'(all_outs), 128'(0));
        rst = 1'b0;
        step();
        check("idle_outs", 128'(all_outs), 128'(0));

        // I-fill alone
        step();
        n = cyc;
        bus.ic_req = 1'b1; bus.ic_addr = 16'h1236;
        push_fill(1'b1, n, 16'h1236, 8, 8, 1'b1);
        step();
        check("ifill_grant", 128'({bus.ic_grant, bus.dc_grant}), 128'(2'b10));
        wait_for(0, "ifill_done");
        bus.ic_req = 1'b0;
        $display("txn ifill_alone start=%0d", n);

        // Simultaneous I and D: D first, I re-arbitrated after
        step();
        n = cyc;
        bus.ic_req = 1'b1; bus.ic_addr = 16'h1236;
        bus.dc_req = 1'b1; bus.dc_addr = 16'h4000;
        push_fill(1'b0, n, 16'h4000, 8, 8, 1'b1);
        push_fill(1'b1, n + WORDS + MEM_LATENCY + 1, 16'h1236, 8, 8, 1'b1);
        step();
        check("dual_grant", 128'({bus.ic_grant, bus.dc_grant}), 128'(2'b01));
        wait_for(1, "dual_dc_done");
        bus.dc_req = 1'b0;
        wait_for(0, "dual_ic_done");
        bus.ic_req = 1'b0;
        $display("txn dual_fill start=%0d", n);

        // Write-through arriving mid-fill waits for the fill
        step();
        n = cyc;
        bus.ic_req = 1'b1; bus.ic_addr = 16'h3456;
        push_fill(1'b1, n, 16'h3456, 8, 8, 1'b1);
        exp_write.push_back({32'(n + WORDS + MEM_LATENCY + 2), 1'b1, 1'b1, 16'h0040, 16'hBEEF});
        repeat (3) step();
        bus.wt_req = 1'b1; bus.wt_addr = 16'h0040; bus.wt_data = 16'hBEEF;
        wait_for(0, "wtfill_ic_done");
        bus.ic_req = 1'b0;
        wait_for(2, "wtfill_ack");
        bus.wt_req = 1'b0;
        $display("txn write_during_fill start=%0d", n);

        // Reset mid-fill
        step();
        n = cyc;
        bus.ic_req = 1'b1; bus.ic_addr = 16'h2000;
        push_fill(1'b1, n, 16'h2000, 6, 2, 1'b0);
        repeat (6) step();
        rst = 1'b1;
        bus.ic_req = 1'b0;
        for (int k = 7; k <= 12; k++) begin
            step();
            rst = 1'b0;
            stray_v = (k >= 11);
            check($sformatf("rst_outs_n%0d", k), 128'(all_outs), 128'(0));
        end
        step();
        stray_v = 1'b0;
        $display("txn reset_mid_fill start=%0d", n);

        // Requester drops dc_req mid-fill
        step();
        n = cyc;
        bus.dc_req = 1'b1; bus.dc_addr = 16'h5678;
        push_fill(1'b0, n, 16'h5678, 8, 8, 1'b1);
        repeat (2) step();
        bus.dc_req = 1'b0;
        wait_for(1, "drop_dc_done");
        $display("txn request_drop start=%0d", n);

        // Back-to-back stores with one IDLE between
        step();
        n = cyc;
        bus.wt_req = 1'b1; bus.wt_addr = 16'h0100; bus.wt_data = 16'h1111;
        exp_write.push_back({32'(n + 1), 1'b1, 1'b1, 16'h0100, 16'h1111});
        exp_write.push_back({32'(n + 3), 1'b1, 1'b1, 16'h0100, 16'h2222});
        wait_for(2, "b2b_ack1");
        bus.wt_data = 16'h2222;
        wait_for(2, "b2b_ack2");
        bus.wt_req = 1'b0;
        $display("txn back_to_back_writes start=%0d", n);

        repeat (8) step();
        check("sb_drain", 128'(exp_issue.size() + exp_beat.size() + exp_done.size()
                               + exp_write.size()), 128'(0));
        check("final_idle", 128'(all_outs), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
